// File: rtl/dmac_xfer_counter.sv
// rtl/dmac_xfer_counter.sv - DMA channel size/burst bookkeeping counters and status flags
// Optional DMAC_XFER_STATUS_EN adds burst_done_cnt and xfer_done status outputs.
module dmac_xfer_counter #(
  parameter int TS_W = 16,
  parameter int BL_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TS_W-1:0] cfg_trans_size,
  input  logic [BL_W-1:0] cfg_burst_len,
  input  logic            t_sel,
  input  logic            sz_en,
  input  logic            burst_en,
  input  logic            b_sel,
  input  logic            ts_en,
  input  logic            count_en,
  output logic            bsz,
  output logic            tslb,
  output logic            tsz,
  output logic [TS_W-1:0] remaining,
  output logic [BL_W-1:0] beat_cnt,
  output logic [BL_W-1:0] cur_len,
  output logic            err
`ifdef DMAC_XFER_STATUS_EN
  ,
  output logic [7:0]      burst_done_cnt,
  output logic            xfer_done
`endif
);

  logic [TS_W-1:0] remaining_q, remaining_d;
  logic [BL_W-1:0] cur_len_q, cur_len_d;
  logic [BL_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BL_W-1:0] burst_len_q, burst_len_d;
  logic            err_q, err_d;

  logic [BL_W-1:0] cfg_len;
  logic [BL_W-1:0] rem_len;
  logic [TS_W-1:0] cur_len_ext;
  logic            load_cfg;
  logic            underflow;

  // A programmed burst length of zero behaves as a single-beat burst.
  assign cfg_len     = (cfg_burst_len == '0) ? BL_W'(1) : cfg_burst_len;
  assign rem_len     = (remaining_q[BL_W-1:0] == '0) ? BL_W'(1) : remaining_q[BL_W-1:0];
  assign cur_len_ext = {{(TS_W-BL_W){1'b0}}, cur_len_q};
  assign load_cfg    = sz_en && t_sel;
  assign underflow   = cur_len_ext > remaining_q;

  assign bsz  = (beat_cnt_q == cur_len_q - BL_W'(1));
  assign tsz  = (remaining_q == '0);
  assign tslb = !tsz && (remaining_q < {{(TS_W-BL_W){1'b0}}, burst_len_q});

  assign remaining = remaining_q;
  assign beat_cnt  = beat_cnt_q;
  assign cur_len   = cur_len_q;
  assign err       = err_q;

  always_comb begin
    remaining_d = remaining_q;
    err_d       = err_q;
    burst_len_d = burst_len_q;
    if (sz_en) begin
      remaining_d = t_sel ? cfg_trans_size : '0;
    end else if (ts_en) begin
      if (underflow) begin
        remaining_d = '0;
        err_d       = 1'b1;
      end else begin
        remaining_d = remaining_q - cur_len_ext;
      end
    end
    if (load_cfg) begin
      err_d       = 1'b0;
      burst_len_d = cfg_len;
    end
  end

  // An explicit burst_en overrides the implicit cur_len load from sz_en.
  always_comb begin
    cur_len_d = cur_len_q;
    if (burst_en) begin
      cur_len_d = b_sel ? rem_len : cfg_len;
    end else if (load_cfg) begin
      cur_len_d = cfg_len;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (sz_en || burst_en) begin
      beat_cnt_d = '0;
    end else if (count_en) begin
      beat_cnt_d = bsz ? '0 : beat_cnt_q + BL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
      cur_len_q   <= BL_W'(1);
      beat_cnt_q  <= '0;
      burst_len_q <= BL_W'(1);
      err_q       <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      cur_len_q   <= cur_len_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
      err_q       <= err_d;
    end
  end

`ifdef DMAC_XFER_STATUS_EN
  logic [7:0] burst_done_cnt_q, burst_done_cnt_d;
  logic       xfer_done_q, xfer_done_d;

  always_comb begin
    burst_done_cnt_d = burst_done_cnt_q;
    if (sz_en) begin
      burst_done_cnt_d = '0;
    end else if (ts_en) begin
      burst_done_cnt_d = burst_done_cnt_q + 8'd1;
    end
  end

  // Any ts_en that empties a nonzero remaining counts, including an underflow.
  assign xfer_done_d = !sz_en && ts_en && !tsz && (cur_len_ext >= remaining_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_done_cnt_q <= '0;
      xfer_done_q      <= 1'b0;
    end else begin
      burst_done_cnt_q <= burst_done_cnt_d;
      xfer_done_q      <= xfer_done_d;
    end
  end

  assign burst_done_cnt = burst_done_cnt_q;
  assign xfer_done      = xfer_done_q;
`endif

endmodule
